// File: rtl/jet_stream_pkg.sv
// Shared types for the jet-tagging stream datapath.
// Frame-collector state and count-width helper.
package jet_stream_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_t;

  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stream_to_vector_p4_if.sv
// Serial-in / vector-out handshake bundle.
// slave = collector side, master = producer/consumer side.
interface stream_to_vector_p4_if
  import jet_stream_pkg::*;
#(
  parameter int WIDTH      = 17,
  parameter int INPUT_SIZE = 32
);
  localparam int CW = count_w(INPUT_SIZE);

  logic signed [WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out_data [INPUT_SIZE];
  logic [CW-1:0]           out_count;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_valid
  );
endinterface

// File: rtl/stream_to_vector_p4.sv
// Packs a serial sample stream into a zero-padded lane vector
// for the adder tree, with back-to-back frame support.
module stream_to_vector_p4
  import jet_stream_pkg::*;
#(
  parameter int WIDTH      = 17,
  parameter int INPUT_SIZE = 32
) (
  input  logic clk,
  input  logic reset,
  stream_to_vector_p4_if.slave bus
);
  localparam int IW = $clog2(INPUT_SIZE);
  localparam int CW = count_w(INPUT_SIZE);

  fill_state_t r_state;
  fill_state_t w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic signed [WIDTH-1:0] r_data [INPUT_SIZE];
  logic signed [WIDTH-1:0] w_data_nxt [INPUT_SIZE];

  logic w_in_ready;
  logic w_accept;
  logic w_at_end;
  logic w_done;

  assign w_in_ready = !reset &&
    (r_state == FILL || bus.out_ready);
  assign w_accept = bus.in_valid && w_in_ready;
  assign w_at_end = (r_idx == IW'(INPUT_SIZE - 1));
  assign w_done   = w_accept && (w_at_end || bus.in_last);

  // Next state, lane index and frame count.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_count_nxt = r_count;
    unique case (r_state)
      FILL: if (w_done) w_state_nxt = FULL;
      FULL: if (bus.out_ready)
        w_state_nxt = w_done ? FULL : FILL;
    endcase
    if (w_done) begin
      w_idx_nxt   = '0;
      w_count_nxt = CW'(r_idx) + CW'(1);
    end else if (w_accept) begin
      w_idx_nxt = r_idx + 1'b1;
    end
  end

  // Per-lane write / zero-pad decode.
  for (genvar g = 0; g < INPUT_SIZE; g++) begin : g_lane
    logic w_wr;
    logic w_clr;
    assign w_wr  = w_accept && (r_idx == IW'(g));
    assign w_clr = w_done && (IW'(g) > r_idx);
    assign w_data_nxt[g] = w_wr  ? bus.in_data :
                           w_clr ? '0 : r_data[g];
  end

  // State and vector registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_count <= '0;
      for (int i = 0; i < INPUT_SIZE; i++)
        r_data[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_count = r_count;
  assign bus.out_data  = r_data;

endmodule

// File: tb/tb_stream_to_vector_p4.sv
// Self-checking bench for stream_to_vector_p4.
// Directed scenarios followed by random traffic vs a frame model.
module tb_stream_to_vector_p4;
  localparam int W  = 17;
  localparam int N  = 32;
  localparam int CW = $clog2(N + 1);

  logic clk;
  logic reset;

  stream_to_vector_p4_if #(.WIDTH(W), .INPUT_SIZE(N)) bus ();

  stream_to_vector_p4 #(.WIDTH(W), .INPUT_SIZE(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: samples of the frame being gathered, plus the
  // frame currently presented downstream (if any).
  int cur[$];
  logic signed [W-1:0] m_frame [N];
  int m_count = 0;
  bit m_full  = 0;
  bit m_fresh = 1;

  task automatic check_out();
    int exp_cnt;
    logic signed [W-1:0] exp_lane;
    bit ok;
    int bl;
    total++;
    assert (bus.out_valid === m_full) else begin
      bad++;
      $error("FAIL out_valid got=%0b exp=%0b", bus.out_valid, m_full);
    end
    if (m_full || m_fresh) begin
      exp_cnt = m_full ? m_count : 0;
      total++;
      assert (bus.out_count === CW'(exp_cnt)) else begin
        bad++;
        $error("FAIL out_count got=%0d exp=%0d", bus.out_count, exp_cnt);
      end
      ok = 1;
      bl = 0;
      for (int i = 0; i < N; i++) begin
        exp_lane = m_full ? m_frame[i] : '0;
        if (ok && bus.out_data[i] !== exp_lane) begin
          ok = 0;
          bl = i;
        end
      end
      exp_lane = m_full ? m_frame[bl] : '0;
      total++;
      assert (ok) else begin
        bad++;
        $error("FAIL out_data lane=%0d got=%0d exp=%0d",
               bl, bus.out_data[bl], exp_lane);
      end
    end
  endtask

  task automatic step(input bit v, input int d, input bit last,
                      input bit ordy, input bit rst);
    bit exp_rdy;
    reset         = rst;
    bus.in_valid  = v;
    bus.in_data   = W'(d);
    bus.in_last   = last;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !rst && (!m_full || ordy);
    total++;
    assert (bus.in_ready === exp_rdy) else begin
      bad++;
      $error("FAIL in_ready got=%0b exp=%0b", bus.in_ready, exp_rdy);
    end
    @(posedge clk);
    if (rst) begin
      cur.delete();
      m_full  = 0;
      m_fresh = 1;
      m_count = 0;
    end else begin
      if (m_full && ordy) m_full = 0;
      if (v && exp_rdy) begin
        m_fresh = 0;
        cur.push_back(d);
        if (cur.size() == N || last) begin
          for (int i = 0; i < N; i++)
            m_frame[i] = (i < cur.size()) ? W'(cur[i]) : '0;
          m_count = cur.size();
          m_full  = 1;
          cur.delete();
        end
      end
    end
    #1;
    check_out();
  endtask

  initial begin
    int sum;
    int sv[5];
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // full frame 1..32
    for (int i = 1; i <= N; i++) step(1, i, 0, 1, 0);
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(bus.out_data[i]);
    total++;
    assert (sum === 528) else begin
      bad++;
      $error("FAIL tree_sum got=%0d exp=528", sum);
    end

    // short frame, then downstream stall
    sv = '{3, -4, 7, 1, -8};
    for (int i = 0; i < 5; i++) step(1, sv[i], i == 4, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 77, 0, 0, 0);
    for (int i = 0; i < N; i++) step(1, 200 + i, 0, 1, 0);

    // back-to-back frames
    for (int i = 1; i <= N; i++) step(1, i, 0, 1, 0);
    for (int i = 101; i <= 100 + N; i++) step(1, i, 0, 1, 0);

    // abort mid-frame by reset
    for (int i = 0; i < 17; i++) step(1, 50 + i, 0, 1, 0);
    step(1, 99, 0, 1, 1);
    step(1, 9, 0, 1, 0);
    step(1, 9, 1, 1, 0);

    // single-beat frame accepted while FULL
    step(1, 5, 0, 0, 0);
    step(1, 6, 1, 0, 0);
    step(1, -42, 1, 1, 0);
    total++;
    assert (bus.out_count === CW'(1)) else begin
      bad++;
      $error("FAIL single_beat count got=%0d exp=1", bus.out_count);
    end
    step(0, 0, 0, 1, 0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 131071)) - 65536,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 150) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
